// File: rtl/fft_frame_monitor.sv
// fft_frame_monitor: watches the valid strobes around an FFT core and checks
// that every input frame of FRAME_LEN samples is answered by an output burst of
// FRAME_LEN samples within MAX_LAT cycles. It reports per-frame latency, a
// frame counter and sticky protocol error flags.
// Optional feature: define FFT_MON_CHECKSUM_EN to build the output-data
// checksum accumulator; otherwise checksum is tied to zero.
module fft_frame_monitor #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_LAT   = 1000,
    localparam int unsigned CNT_W    = $clog2(FRAME_LEN + 1),
    localparam int unsigned LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     out_valid,
    input  logic signed [DATA_W-1:0] out_yp_real,
    input  logic signed [DATA_W-1:0] out_yp_img,
    input  logic                     err_clr,
    output logic                     frame_done,
    output logic [LAT_W-1:0]         latency,
    output logic [15:0]              frame_cnt,
    output logic                     err_in_len,
    output logic                     err_out_len,
    output logic                     err_timeout,
    output logic                     err_overlap,
    output logic                     err_spurious,
    output logic                     busy,
    output logic [2*DATA_W-1:0]      checksum
);

    typedef enum logic [1:0] {StIdle, StInput, StWait, StOutput} state_t;

    localparam logic [CNT_W-1:0] LenC    = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] SatC    = CNT_W'(FRAME_LEN + 1);
    localparam logic [LAT_W:0]   MaxLatC = (LAT_W + 1)'(MAX_LAT);

    state_t             state;
    logic [CNT_W-1:0]   in_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [LAT_W-1:0]   lat;
    logic [LAT_W-1:0]   lat_cap;
    logic [LAT_W:0]     lat_inc;

    logic ev_in_len, ev_out_len, ev_timeout, ev_overlap, ev_spurious;

    // lat holds cycles elapsed since the first in_valid-low cycle, not counting
    // the current one; lat_inc includes the current cycle and is what gets
    // reported and compared against MAX_LAT. One extra bit avoids overflow.
    assign lat_inc = {1'b0, lat} + (LAT_W + 1)'(1);

    // Error events seen this cycle, derived from the current state and strobes
    always_comb begin
        ev_spurious = (state == StIdle) && out_valid;
        ev_overlap  = ((state == StInput) && out_valid) ||
                      (((state == StWait) || (state == StOutput)) && in_valid);
        ev_in_len   = (state == StInput) && !in_valid && (in_cnt != LenC);
        ev_timeout  = (state == StWait) && !out_valid && (lat_inc >= MaxLatC);
        ev_out_len  = (state == StOutput) && !out_valid && (out_cnt != LenC);
    end

    assign busy = (state != StIdle);

    // Frame FSM, counters, latency/frame results and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            in_cnt       <= '0;
            out_cnt      <= '0;
            lat          <= '0;
            lat_cap      <= '0;
            latency      <= '0;
            frame_cnt    <= '0;
            frame_done   <= 1'b0;
            err_in_len   <= 1'b0;
            err_out_len  <= 1'b0;
            err_timeout  <= 1'b0;
            err_overlap  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A new event wins over a simultaneous clear
            err_in_len   <= ev_in_len   | (err_in_len   & ~err_clr);
            err_out_len  <= ev_out_len  | (err_out_len  & ~err_clr);
            err_timeout  <= ev_timeout  | (err_timeout  & ~err_clr);
            err_overlap  <= ev_overlap  | (err_overlap  & ~err_clr);
            err_spurious <= ev_spurious | (err_spurious & ~err_clr);

            case (state)
                StIdle: begin
                    if (in_valid) begin
                        state  <= StInput;
                        in_cnt <= CNT_W'(1);
                    end
                end
                StInput: begin
                    if (in_valid) begin
                        if (in_cnt != SatC) in_cnt <= in_cnt + CNT_W'(1);
                    end else begin
                        state <= StWait;
                        lat   <= LAT_W'(1);
                    end
                end
                StWait: begin
                    if (out_valid) begin
                        state   <= StOutput;
                        out_cnt <= CNT_W'(1);
                        lat_cap <= lat_inc[LAT_W-1:0];
                    end else if (ev_timeout) begin
                        state <= StIdle;
                    end else begin
                        lat <= lat_inc[LAT_W-1:0];
                    end
                end
                StOutput: begin
                    if (out_valid) begin
                        if (out_cnt != SatC) out_cnt <= out_cnt + CNT_W'(1);
                    end else begin
                        // in_valid on this cycle cannot start a frame
                        state <= StIdle;
                        if (out_cnt == LenC) begin
                            frame_done <= 1'b1;
                            latency    <= lat_cap;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef FFT_MON_CHECKSUM_EN
    logic [2*DATA_W-1:0] sample;
    assign sample = {out_yp_real, out_yp_img};

    // Checksum restarts with the first sample of a burst, then accumulates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if ((state == StWait) && out_valid) begin
            checksum <= sample;
        end else if ((state == StOutput) && out_valid) begin
            checksum <= checksum + sample;
        end
    end
`else
    logic unused_data;
    assign unused_data = ^{out_yp_real, out_yp_img};
    assign checksum    = '0;
`endif

endmodule

// File: tb/tb_fft_frame_monitor.sv
// Self-checking bench for fft_frame_monitor: directed scenarios with literal
// expectations plus randomized frames checked every cycle against a
// timestamp-based reference model.
module tb_fft_frame_monitor;

    localparam int FL = 256;
    localparam int DW = 16;
    localparam int ML = 1000;
    localparam int LW = $clog2(ML + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_valid = 1'b0;
    logic err_clr = 1'b0;
    logic signed [DW-1:0] re = '0;
    logic signed [DW-1:0] im = '0;

    logic          frame_done, busy;
    logic [LW-1:0] latency;
    logic [15:0]   frame_cnt;
    logic          err_in_len, err_out_len, err_timeout, err_overlap, err_spurious;
    logic [2*DW-1:0] checksum;

    fft_frame_monitor #(.FRAME_LEN(FL), .DATA_W(DW), .MAX_LAT(ML)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .out_valid    (out_valid),
        .out_yp_real  (re),
        .out_yp_img   (im),
        .err_clr      (err_clr),
        .frame_done   (frame_done),
        .latency      (latency),
        .frame_cnt    (frame_cnt),
        .err_in_len   (err_in_len),
        .err_out_len  (err_out_len),
        .err_timeout  (err_timeout),
        .err_overlap  (err_overlap),
        .err_spurious (err_spurious),
        .busy         (busy),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int clr_pct = 0;
    bit fixed_data = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the frame by cycle timestamps: latency is the number of cycles
    // from the first in_valid-low cycle up to and including the first
    // out_valid cycle.
    localparam int PH_IDLE = 0, PH_IN = 1, PH_WAIT = 2, PH_OUT = 3;
    int cyc, m_ph, n_in, n_out, t_drop, cap;
    logic          m_done;
    logic [LW-1:0] m_lat;
    logic [15:0]   m_cnt;
    logic [4:0]    m_err;  // {in_len, out_len, timeout, overlap, spurious}
    logic [31:0]   m_sum;

    always @(posedge clk or posedge rst) begin : model
        logic [4:0] ev;
        if (rst) begin
            cyc = 0; m_ph = PH_IDLE; n_in = 0; n_out = 0; t_drop = 0; cap = 0;
            m_done = 1'b0; m_lat = '0; m_cnt = '0; m_err = '0; m_sum = '0;
        end else begin
            ev = '0;
            m_done = 1'b0;
            case (m_ph)
                PH_IDLE: begin
                    if (out_valid) ev[0] = 1'b1;
                    if (in_valid) begin m_ph = PH_IN; n_in = 1; end
                end
                PH_IN: begin
                    if (out_valid) ev[1] = 1'b1;
                    if (in_valid) n_in++;
                    else begin
                        m_ph = PH_WAIT;
                        t_drop = cyc;
                        if (n_in != FL) ev[4] = 1'b1;
                    end
                end
                PH_WAIT: begin
                    if (in_valid) ev[1] = 1'b1;
                    if (out_valid) begin
                        m_ph = PH_OUT;
                        n_out = 1;
                        cap = cyc - t_drop + 1;
                        m_sum = {re, im};
                    end else if (cyc - t_drop + 1 >= ML) begin
                        ev[2] = 1'b1;
                        m_ph = PH_IDLE;
                    end
                end
                default: begin
                    if (in_valid) ev[1] = 1'b1;
                    if (out_valid) begin
                        n_out++;
                        m_sum = m_sum + {re, im};
                    end else begin
                        m_ph = PH_IDLE;
                        if (n_out == FL) begin
                            m_done = 1'b1;
                            m_lat = LW'(cap);
                            m_cnt = m_cnt + 16'd1;
                        end else ev[3] = 1'b1;
                    end
                end
            endcase
            m_err = ev | (m_err & ~{5{err_clr}});
            cyc++;
        end
    end

    function automatic logic [31:0] exp_sum();
`ifdef FFT_MON_CHECKSUM_EN
        return m_sum;
`else
        return 32'h0;
`endif
    endfunction

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("cycle_ctrl",
                64'({frame_done, latency, frame_cnt, err_in_len, err_out_len,
                     err_timeout, err_overlap, err_spurious, busy}),
                64'({m_done, m_lat, m_cnt, m_err, 1'(m_ph != PH_IDLE)}));
            chk("cycle_checksum", 64'(checksum), 64'(exp_sum()));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic rclr();
        return 1'($urandom_range(99) < clr_pct);
    endfunction

    task automatic step(input logic iv, input logic ov, input logic clr);
        in_valid = iv;
        out_valid = ov;
        err_clr = clr;
        if (ov) begin
            re = fixed_data ? 16'sd1 : DW'($urandom);
            im = fixed_data ? -16'sd1 : DW'($urandom);
        end
        @(negedge clk);
    endtask

    // ni input cycles, gap quiet cycles, no output cycles, then one quiet
    // cycle that ends the burst; ovl_pct injects in_valid during output.
    task automatic frame(input int ni, input int gap, input int no, input int ovl_pct);
        for (int i = 0; i < ni; i++) step(1'b1, 1'b0, rclr());
        for (int i = 0; i < gap; i++) step(1'b0, 1'b0, rclr());
        for (int i = 0; i < no; i++)
            step(1'($urandom_range(99) < ovl_pct), 1'b1, rclr());
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        in_valid = 1'b0; out_valid = 1'b0; err_clr = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int pick_len();
        case ($urandom_range(3))
            0, 1: return FL;
            2: return ($urandom_range(1) == 0) ? FL - 1 : FL + 1;
            default: return int'($urandom_range(FL + 3, 1));
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            64'({frame_done, latency, frame_cnt, err_in_len, err_out_len, err_timeout,
                 err_overlap, err_spurious, busy, checksum}), 64'd0);
        rst = 1'b0;

        // Legal frame with constant samples
        fixed_data = 1'b1;
        frame(FL, 40, FL, 0);
        chk("legal_done_pulse", 64'(frame_done), 64'd1);
        chk("legal_latency", 64'(latency), 64'd41);
        chk("legal_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("legal_no_errors", 64'({err_in_len, err_out_len, err_timeout, err_overlap,
                                    err_spurious}), 64'd0);
`ifdef FFT_MON_CHECKSUM_EN
        chk("legal_checksum", 64'(checksum), 64'h01FFFF00);
`else
        chk("legal_checksum", 64'(checksum), 64'd0);
`endif
        step(1'b0, 1'b0, 1'b0);
        chk("done_one_cycle", 64'(frame_done), 64'd0);

        // Short output burst
        reset_pulse();
        frame(FL, 40, FL - 1, 0);
        chk("short_err_out_len", 64'(err_out_len), 64'd1);
        chk("short_no_done", 64'(frame_done), 64'd0);
        chk("short_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("short_latency", 64'(latency), 64'd0);

        // Timeout: flag appears exactly ML cycles after the first low cycle
        reset_pulse();
        for (int i = 0; i < FL; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < ML - 1; i++) step(1'b0, 1'b0, 1'b0);
        chk("timeout_not_early", 64'(err_timeout), 64'd0);
        chk("timeout_busy_before", 64'(busy), 64'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("timeout_flag", 64'(err_timeout), 64'd1);
        chk("timeout_idle", 64'(busy), 64'd0);

        // Protocol errors and clear
        reset_pulse();
        step(1'b0, 1'b1, 1'b0);
        chk("spurious_flag", 64'(err_spurious), 64'd1);
        frame(FL, 10, FL, 100);
        chk("overlap_flag", 64'(err_overlap), 64'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("clear_all", 64'({err_in_len, err_out_len, err_timeout, err_overlap,
                              err_spurious}), 64'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("event_beats_clear", 64'(err_spurious), 64'd1);
        step(1'b0, 1'b0, 1'b1);

        // Mid-frame reset at output sample 100
        reset_pulse();
        for (int i = 0; i < FL; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_ctrl",
            64'({frame_done, latency, frame_cnt, err_in_len, err_out_len, err_timeout,
                 err_overlap, err_spurious, busy}), 64'd0);
        chk("async_reset_checksum", 64'(checksum), 64'd0);
        in_valid = 1'b0; out_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        frame(FL, 40, FL, 0);
        chk("after_reset_frame_cnt", 64'(frame_cnt), 64'd1);

        // Randomized frames checked by the model
        fixed_data = 1'b0;
        clr_pct = 5;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(4) == 0) step(1'b0, 1'b1, 1'b0);
            frame(pick_len(), int'($urandom_range(60)), pick_len(),
                  ($urandom_range(3) == 0) ? 2 : 0);
            if ($urandom_range(1) == 0) step(1'b0, 1'b0, rclr());
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_monitor.md
FFT_FRAME_MONITOR -- requirements
Module: fft_frame_monitor

Interface
REQ-001 Parameter FRAME_LEN, default 256, samples per input frame and per output frame; SHALL be a value of at least 2.
REQ-002 Parameter DATA_W, default 16, width of each signed real or imaginary output sample.
REQ-003 Parameter MAX_LAT, default 1000, maximum allowed latency in cycles; SHALL be a value of at least 1.
REQ-004 Derived widths: CNT_W = $clog2(FRAME_LEN+1); LAT_W = $clog2(MAX_LAT+1).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  DUT input-sample strobe.
REQ-008 out_valid  in  1  DUT output-sample strobe.
REQ-009 out_yp_real, out_yp_img  in  DATA_W each  signed DUT output sample.
REQ-010 err_clr  in  1  synchronous clear of all sticky error flags.
REQ-011 frame_done  out  1  one-cycle pulse after a legal output burst completes.
REQ-012 latency  out  LAT_W  latency of the last frame; held until the next frame_done.
REQ-013 frame_cnt  out  16  number of legal frames completed; wraps from 16'hFFFF to 0.
REQ-014 err_in_len, err_out_len, err_timeout, err_overlap, err_spurious  out  1 each  sticky error flags.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 checksum  out  2*DATA_W  output-data checksum (see Configuration).

Function
REQ-017 FSM states: IDLE, INPUT, WAIT, OUTPUT.
REQ-018 IDLE: in_valid=1 -> INPUT with in_cnt=1. out_valid=1 -> set err_spurious and stay in IDLE. If both are high, the in_valid action and err_spurious both happen.
REQ-019 INPUT: in_cnt counts cycles with in_valid high. When in_valid drops, go to WAIT. If in_cnt != FRAME_LEN at that point, set err_in_len. The lat counter is loaded to 1 on entry to WAIT.
REQ-020 INPUT: in_cnt saturates at FRAME_LEN+1. out_valid=1 while in INPUT -> set err_overlap; the sample is not counted.
REQ-021 WAIT: lat counts one per cycle while out_valid=0. The first out_valid=1 -> OUTPUT with out_cnt=1, and the current lat value is captured.
REQ-022 WAIT: when lat reaches MAX_LAT with out_valid still 0 -> set err_timeout, return to IDLE, leave latency unchanged. in_valid=1 in WAIT -> set err_overlap and stay in WAIT.
REQ-023 OUTPUT: out_cnt counts cycles with out_valid high and saturates at FRAME_LEN+1.
REQ-024 OUTPUT end of burst: on the first cycle with out_valid=0, go to IDLE. If out_cnt == FRAME_LEN: pulse frame_done, load latency with the captured lat, increment frame_cnt. Otherwise set err_out_len and leave latency and frame_cnt unchanged.
REQ-025 OUTPUT: in_valid=1 -> set err_overlap.
REQ-026 A new in_valid in the same cycle that the burst ends (OUTPUT -> IDLE) is ignored. The next frame starts only from IDLE.
REQ-027 Error flags are sticky until err_clr or rst. If err_clr and a new error event occur in the same cycle, the event wins and the flag is set.
REQ-028 err_clr has no effect on the FSM, counters, latency, frame_cnt or checksum.

Reset
REQ-029 On rst=1, immediately and independent of clk: state=IDLE; all counters, latency, frame_cnt and checksum = 0; all error flags, frame_done and busy = 0.
REQ-030 Reset asserted mid-frame abandons the frame with no error and no frame_done. Monitoring resumes on the first clock edge after rst deasserts.

Configuration
REQ-031 Macro FFT_MON_CHECKSUM_EN.
- Defined: checksum is cleared on entry to OUTPUT. Each cycle with out_valid=1 in OUTPUT adds {out_yp_real, out_yp_img}, treated as unsigned, modulo 2^(2*DATA_W). The value is frozen from frame end until the next OUTPUT entry.
- Undefined: checksum is constant 0 and no accumulator logic is synthesised.

Verification
REQ-032 Legal frame: FRAME_LEN=256; 256 cycles in_valid; 40 idle cycles; 256 cycles out_valid. Expect frame_done pulse, latency=41, frame_cnt=1, no errors.
REQ-033 Short output: same as REQ-032 but with 255 output cycles. Expect err_out_len=1, no frame_done, frame_cnt=0, latency=0.
REQ-034 Timeout: MAX_LAT=1000; 256 input cycles, then no out_valid. Expect err_timeout=1 exactly 1000 cycles after in_valid drops, then state IDLE and busy=0.
REQ-035 Protocol errors:
- out_valid pulse while in IDLE -> err_spurious=1.
- in_valid during OUTPUT -> err_overlap=1.
- Then err_clr pulse -> all flags 0 on the next cycle.
REQ-036 Mid-frame reset: rst pulse at output sample 100. Expect all outputs 0 immediately. A following legal frame gives frame_cnt=1.
REQ-037 Checksum: with FFT_MON_CHECKSUM_EN defined, 256 output samples each with real=1 and img=-1 give checksum = 256*32'h0001FFFF mod 2^32 = 32'h01FFFF00. Without the macro, checksum stays 0.
